vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Free-running 640x480@60 Hz raster timing generator clocked by the 25 MHz pixel clock. It produces the `DrawX`/`DrawY`/`blank` coordinate stream consumed by every sprite and background renderer. It also drives the board's sync pins. An optional frame/second tick counter paces on-screen countdowns and animations.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch, in pixels
- `H_SYNC`, 96, hsync pulse width, in pixels
- `H_BP`, 48, horizontal back porch, in pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vsync pulse width, in lines
- `V_BP`, 33, vertical back porch, in lines
- `vga_clk`  in  1  pixel clock; all logic on its rising edge
- `reset_n`  in  1  synchronous active-low reset
- `DrawX`  out  10  current horizontal counter, 0..H_TOTAL-1
- `DrawY`  out  10  current vertical counter, 0..V_TOTAL-1
- `blank`  out  1  1 = visible pixel (DrawX<H_ACTIVE and DrawY<V_ACTIVE); renderers output colour only when high
- `hs`  out  1  horizontal sync, active-low
- `vs`  out  1  vertical sync, active-low
- `line_start`  out  1  one-cycle pulse while DrawX==0
- `frame_start`  out  1  one-cycle pulse while DrawX==0 and DrawY==0
- `frame_count`  out  6  frames within the current second, 0..59 (VGA_FRAME_TICK_EN only)
- `sec_tick`  out  1  one-cycle pulse coincident with frame_start when frame_count wraps 59→0 (VGA_FRAME_TICK_EN only)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL likewise (default 525). Both must be ≤1024. Elaboration fails otherwise.
- Horizontal counter h: 0..H_TOTAL-1, +1 per cycle, wraps to 0.
- Vertical counter v: +1 when h wraps, itself wraps V_TOTAL-1→0. Counter arithmetic is 10-bit unsigned, no overflow.
- h=H_TOTAL-1 and v=V_TOTAL-1 together: next cycle is (0,0), frame_start asserted.
- hs=0 iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751).
- vs=0 iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491). vs changes on the same cycle DrawY changes.
- All outputs are registered and mutually aligned. DrawX/DrawY/blank/hs/vs/pulses always describe the same pixel.
- Two states: RESET (held while reset_n=0) and RUN.
- Reset values: DrawX=0, DrawY=0, blank=0, hs=1, vs=1, line_start=0, frame_start=0, frame_count=0, sec_tick=0.
- First rising edge with reset_n=1: outputs describe pixel (0,0), so blank=1, line_start=1, frame_start=1. Counting starts from there.
- Reset asserted mid-frame: next edge returns to reset values regardless of position. There is no partial-frame recovery.

## Timing
- Latency: zero cycles between DrawX/DrawY and their decoded blank/hs/vs. Decodes are computed from next-state counters and registered together.
- Renderers read ROM on the falling edge and register colour on the next rising edge. The consumer therefore adds exactly one cycle of pixel pipeline. The generator does not compensate for it.
- Line period: H_TOTAL cycles. Frame period: H_TOTAL*V_TOTAL = 420000 cycles.
- frame_start period is exactly 420000 cycles. line_start period is exactly 800 cycles.

## Configuration
- Macro `VGA_FRAME_TICK_EN`.
- Defined: the `frame_count` and `sec_tick` ports exist.
  - frame_count increments on each frame_start after the first post-reset frame, and wraps 59→0.
  - sec_tick pulses on the frame_start at which the wrap occurs.
- Undefined: both ports and their logic are absent. Timing outputs are identical.

## Structure
- Package `vga_pkg`:
  - default timing constants
  - `H_TOTAL`/`V_TOTAL` computed constants
  - typedef `coord_t` = logic [9:0]
  - `FRAMES_PER_SEC` = 60
- Sub-module `vga_frame_tick` holds the frame/second counter. Its inputs are vga_clk, reset_n and frame_start. It is instantiated only under VGA_FRAME_TICK_EN.

## Test plan
- Reset held 5 cycles, then released → during reset DrawX=0, DrawY=0, blank=0, hs=1, vs=1. First edge after release: (0,0), blank=1, frame_start=1.
- Run one line → blank falls at DrawX=640. hs=0 for DrawX 656..751, exactly 96 cycles. line_start period is 800.
- Run one frame → vs=0 only for DrawY 490..491, 1600 cycles total. Visible cycles = 307200. (799,524) is followed by (0,0) with frame_start=1.
- Assert reset_n=0 at (300,200) for 1 cycle → outputs return to reset values, then resume at (0,0) with frame_start=1.
- VGA_FRAME_TICK_EN defined, run 61 frames → frame_count sequences 0..59 then 0. Exactly one sec_tick, at the 60th frame_start after the first.
- Override parameters to H 8/1/2/1 and V 4/1/1/1 → line period 12 and frame period 84 cycles, with sync windows at h 9..10 and v 5.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA raster timing generator.
//   - Default 640x480@60 Hz timing constants (pixels / lines).
//   - H_TOTAL / V_TOTAL computed from the defaults.
//   - coord_t: 10-bit raster coordinate type.
//   - FRAMES_PER_SEC: frame count at which the seconds tick fires.
//   - vga_state_t: generator FSM state encoding.
//   - in_window(): half-open range test [lo, hi) on a coordinate.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Largest total a 10-bit counter can step through.
    localparam int MAX_TOTAL = 1024;

    localparam int FRAMES_PER_SEC = 60;

    typedef logic [9:0] coord_t;

    typedef enum logic {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } vga_state_t;

    // Comparison done in the int domain so window ends equal to 1024 do not
    // wrap in 10 bits.
    function automatic logic in_window(input coord_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// vga_frame_tick: frames-within-second counter for on-screen pacing.
//   vga_clk     in   pixel clock, rising edge
//   reset_n     in   synchronous active-low reset
//   frame_start in   high for the cycle whose edge will present pixel (0,0);
//                    the top feeds its next-state decode here so the outputs
//                    land on the same edge as its registered frame_start
//   frame_count out  0..FRAMES_PER_SEC-1, holds for a whole frame
//   sec_tick    out  one-cycle pulse on the frame_start where the count wraps
// The first frame after reset is frame 0; counting begins at the next one.
module vga_frame_tick
    import vga_pkg::*;
(
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_start,
    output logic [5:0] frame_count,
    output logic       sec_tick
);

    localparam logic [5:0] LAST_FRAME = 6'(FRAMES_PER_SEC - 1);

    // Set once the first post-reset frame has begun.
    logic first_seen;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            frame_count <= '0;
            sec_tick    <= 1'b0;
            first_seen  <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            if (frame_start) begin
                if (!first_seen) begin
                    first_seen <= 1'b1;
                end else if (frame_count == LAST_FRAME) begin
                    frame_count <= '0;
                    sec_tick    <= 1'b1;
                end else begin
                    frame_count <= frame_count + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing generator (default 640x480@60).
// Optional feature macro: VGA_FRAME_TICK_EN adds frame_count / sec_tick.
//   vga_clk     in   pixel clock; all logic on its rising edge
//   reset_n     in   synchronous active-low reset
//   DrawX       out  horizontal counter, 0..H_TOTAL-1
//   DrawY       out  vertical counter,   0..V_TOTAL-1
//   blank       out  1 = visible pixel
//   hs, vs      out  active-low sync pulses
//   line_start  out  high while DrawX==0
//   frame_start out  high while DrawX==0 and DrawY==0
//   state       out  FSM state (ST_RESET while held in reset, ST_RUN after)
//   frame_count out  frames within the current second (VGA_FRAME_TICK_EN)
//   sec_tick    out  pulse on the frame_start where frame_count wraps
//                    (VGA_FRAME_TICK_EN)
// Output contract: there is no handshake; every cycle presents exactly one
// pixel, and all outputs are registered on the same edge so they always
// describe that same pixel.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output vga_state_t state
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic [5:0] frame_count,
    output logic       sec_tick
`endif
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam coord_t H_LAST = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST = coord_t'(V_TOT - 1);

    if (H_TOT > MAX_TOTAL || V_TOT > MAX_TOTAL) begin : g_bad_timing
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    // Next-state counters. Leaving reset always lands on (0,0), so the
    // first edge with reset_n high already presents the frame origin.
    coord_t x_nxt;
    coord_t y_nxt;

    always_comb begin
        x_nxt = '0;
        y_nxt = '0;
        if (state == ST_RUN) begin
            if (DrawX == H_LAST) begin
                x_nxt = '0;
                y_nxt = (DrawY == V_LAST) ? '0 : DrawY + coord_t'(1);
            end else begin
                x_nxt = DrawX + coord_t'(1);
                y_nxt = DrawY;
            end
        end
    end

    // Decodes are taken from the next-state counters so that, once
    // registered, they line up with DrawX/DrawY with no added latency.
    logic blank_nxt;
    logic hs_nxt;
    logic vs_nxt;
    logic ls_nxt;
    logic fs_nxt;

    always_comb begin
        blank_nxt = in_window(x_nxt, 0, H_ACTIVE) && in_window(y_nxt, 0, V_ACTIVE);
        hs_nxt    = !in_window(x_nxt, HS_START, HS_END);
        vs_nxt    = !in_window(y_nxt, VS_START, VS_END);
        ls_nxt    = (x_nxt == '0);
        fs_nxt    = (x_nxt == '0) && (y_nxt == '0);
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state       <= ST_RESET;
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= ST_RUN;
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            blank       <= blank_nxt;
            hs          <= hs_nxt;
            vs          <= vs_nxt;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    // Fed with the next-state frame_start so its registered outputs change
    // on the same edge as frame_start itself.
    vga_frame_tick u_frame_tick (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_start (fs_nxt),
        .frame_count (frame_count),
        .sec_tick    (sec_tick)
    );
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen.
//   dut_a: default 640x480 timing, reset / first line / line period.
//   dut_b: tiny timing (H 8/1/2/1, V 4/1/1/1), mid-frame reset and 61 frames
//          (frame tick sequence when VGA_FRAME_TICK_EN is defined).
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int S_HA = 8;
    localparam int S_HF = 1;
    localparam int S_HS = 2;
    localparam int S_HB = 1;
    localparam int S_VA = 4;
    localparam int S_VF = 1;
    localparam int S_VS = 1;
    localparam int S_VB = 1;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;
    localparam int S_RUN_LEN = 61 * S_FRAME;

    typedef struct packed {
        int unsigned tag;
        coord_t      x;
        coord_t      y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic        st;
        logic [5:0]  fc;
        logic        stk;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    initial forever #20 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    coord_t ax, ay, bx, by;
    logic a_blank, a_hs, a_vs, a_ls, a_fs;
    logic b_blank, b_hs, b_vs, b_ls, b_fs;
    vga_state_t a_st, b_st;
    logic [5:0] a_fc, b_fc;
    logic a_stk, b_stk;

    vga_timing_gen dut_a (
        .vga_clk     (clk),
        .reset_n     (rst_a),
        .DrawX       (ax),
        .DrawY       (ay),
        .blank       (a_blank),
        .hs          (a_hs),
        .vs          (a_vs),
        .line_start  (a_ls),
        .frame_start (a_fs),
        .state       (a_st)
`ifdef VGA_FRAME_TICK_EN
        ,
        .frame_count (a_fc),
        .sec_tick    (a_stk)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
    ) dut_b (
        .vga_clk     (clk),
        .reset_n     (rst_b),
        .DrawX       (bx),
        .DrawY       (by),
        .blank       (b_blank),
        .hs          (b_hs),
        .vs          (b_vs),
        .line_start  (b_ls),
        .frame_start (b_fs),
        .state       (b_st)
`ifdef VGA_FRAME_TICK_EN
        ,
        .frame_count (b_fc),
        .sec_tick    (b_stk)
`endif
    );

`ifndef VGA_FRAME_TICK_EN
    assign a_fc  = '0;
    assign a_stk = 1'b0;
    assign b_fc  = '0;
    assign b_stk = 1'b0;
`endif

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic done_a = 1'b0;
    logic done_b = 1'b0;

    logic [EXP_W-1:0] exp_a_q[$];
    logic [EXP_W-1:0] exp_b_q[$];
    string name_a_q[$];
    string name_b_q[$];

    function automatic exp_t mk(int unsigned tag, int x, int y, logic b, logic h, logic v,
                                logic l, logic f, logic s, int fc, logic stk);
        exp_t e;
        e.tag = tag; e.x = coord_t'(x); e.y = coord_t'(y);
        e.blank = b; e.hs = h; e.vs = v; e.ls = l; e.fs = f; e.st = s;
        e.fc = 6'(fc); e.stk = stk;
        return e;
    endfunction

    function automatic exp_t reset_exp(int unsigned tag);
        return mk(tag, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endfunction

    // Expected pixel k cycles after the release edge, tiny timing.
    function automatic exp_t model_s(int unsigned tag, int k);
        int x, y, f, fc;
        logic fs, stk;
        x  = k % S_HT;
        y  = (k / S_HT) % S_VT;
        f  = k / S_FRAME;
        fs = (x == 0) && (y == 0);
        fc = 0;
        stk = 1'b0;
`ifdef VGA_FRAME_TICK_EN
        fc  = f % 60;
        stk = fs && (f > 0) && (f % 60 == 0);
`endif
        return mk(tag, x, y, (x < S_HA) && (y < S_VA),
                  !((x >= S_HA + S_HF) && (x < S_HA + S_HF + S_HS)),
                  !((y >= S_VA + S_VF) && (y < S_VA + S_VF + S_VS)),
                  x == 0, fs, 1'b1, fc, stk);
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("(%0d,%0d) blank=%0b hs=%0b vs=%0b ls=%0b fs=%0b st=%0b fc=%0d stk=%0b",
                         e.x, e.y, e.blank, e.hs, e.vs, e.ls, e.fs, e.st, e.fc, e.stk);
    endfunction

    function automatic void push_a(string nm, exp_t e);
        exp_a_q.push_back(e);
        name_a_q.push_back(nm);
    endfunction

    function automatic void push_b(string nm, exp_t e);
        exp_b_q.push_back(e);
        name_b_q.push_back(nm);
    endfunction

    task automatic check_vec(string nm, exp_t got, exp_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %s, expected %s", nm, cyc, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(string nm, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon_a
        exp_t e;
        exp_t g;
        string nm;
        g.tag = cyc; g.x = ax; g.y = ay; g.blank = a_blank; g.hs = a_hs; g.vs = a_vs;
        g.ls = a_ls; g.fs = a_fs; g.st = a_st; g.fc = a_fc; g.stk = a_stk;
        while (exp_a_q.size() != 0) begin
            e = exp_t'(exp_a_q[0]);
            if (e.tag > cyc) break;
            void'(exp_a_q.pop_front());
            nm = name_a_q.pop_front();
            if (e.tag < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s missed: tag %0d, now %0d, required %s", nm, e.tag, cyc, fmt(e));
            end else begin
                check_vec(nm, g, e);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        exp_t g;
        string nm;
        g.tag = cyc; g.x = bx; g.y = by; g.blank = b_blank; g.hs = b_hs; g.vs = b_vs;
        g.ls = b_ls; g.fs = b_fs; g.st = b_st; g.fc = b_fc; g.stk = b_stk;
        while (exp_b_q.size() != 0) begin
            e = exp_t'(exp_b_q[0]);
            if (e.tag > cyc) break;
            void'(exp_b_q.pop_front());
            nm = name_b_q.pop_front();
            if (e.tag < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s missed: tag %0d, now %0d, required %s", nm, e.tag, cyc, fmt(e));
            end else begin
                check_vec(nm, g, e);
            end
        end
    end

    // ---------------- driver A: default timing ----------------
    initial begin : drv_a
        int unsigned base;
        int nb, nh, ls_cnt, ls_prev, ls_gap;
        rst_a = 1'b0;
        for (int t = 1; t <= 5; t++) push_a("a_in_reset", reset_exp(t));
        repeat (5) @(negedge clk);
        rst_a = 1'b1;
        base = cyc + 1;
        //                          k     x    y  blk hs  vs  ls  fs  st  fc stk
        push_a("a_first_pixel", mk(base + 0,    0,   0, 1, 1, 1, 1, 1, 1, 0, 0));
        push_a("a_second_pixel",mk(base + 1,    1,   0, 1, 1, 1, 0, 0, 1, 0, 0));
        push_a("a_last_visible",mk(base + 639,  639, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        push_a("a_blank_falls", mk(base + 640,  640, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        push_a("a_before_hsync",mk(base + 655,  655, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        push_a("a_hsync_start", mk(base + 656,  656, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        push_a("a_hsync_end",   mk(base + 751,  751, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        push_a("a_after_hsync", mk(base + 752,  752, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        push_a("a_line_end",    mk(base + 799,  799, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        push_a("a_line1_start", mk(base + 800,  0,   1, 1, 1, 1, 1, 0, 1, 0, 0));
        push_a("a_line1_vis",   mk(base + 1439, 639, 1, 1, 1, 1, 0, 0, 1, 0, 0));
        push_a("a_line2_start", mk(base + 1600, 0,   2, 1, 1, 1, 1, 0, 1, 0, 0));
        nb = 0; nh = 0; ls_cnt = 0; ls_prev = 0; ls_gap = 0;
        for (int k = 0; k <= 1600; k++) begin
            @(negedge clk);
            if (k < 800) begin
                if (a_blank) nb++;
                if (!a_hs) nh++;
            end
            if (a_ls) begin
                if (ls_cnt > 0) ls_gap = k - ls_prev;
                ls_prev = k;
                ls_cnt++;
            end
        end
        check_int("a_visible_cycles_line0", nb, 640);
        check_int("a_hsync_low_cycles", nh, 96);
        check_int("a_line_start_count", ls_cnt, 3);
        check_int("a_line_start_period", ls_gap, 800);
        done_a = 1'b1;
    end

    // ---------------- driver B: tiny timing ----------------
    initial begin : drv_b
        int unsigned base;
        int vis, vsl, hsl, fs_cnt, fs_prev, fs_gap, stk_cnt, stk_k;
        rst_b = 1'b0;
        for (int t = 1; t <= 3; t++) push_b("b_in_reset", reset_exp(t));
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        base = cyc + 1;
        for (int k = 0; k <= 29; k++) push_b("b_pre_reset", model_s(base + k, k));
        // k=29 is pixel (5,2): pull reset for one cycle there.
        while (cyc != base + 29) @(negedge clk);
        rst_b = 1'b0;
        push_b("b_mid_frame_reset", reset_exp(cyc + 1));
        @(negedge clk);
        rst_b = 1'b1;
        base = cyc + 1;
        for (int k = 0; k <= S_RUN_LEN; k++) push_b("b_run", model_s(base + k, k));
        vis = 0; vsl = 0; hsl = 0; fs_cnt = 0; fs_prev = 0; fs_gap = 0; stk_cnt = 0; stk_k = -1;
        for (int k = 0; k <= S_RUN_LEN; k++) begin
            @(negedge clk);
            if (k < S_FRAME) begin
                if (b_blank) vis++;
                if (!b_vs) vsl++;
                if (k < S_HT && !b_hs) hsl++;
            end
            if (b_fs) begin
                if (fs_cnt > 0) fs_gap = k - fs_prev;
                fs_prev = k;
                fs_cnt++;
            end
            if (b_stk) begin
                stk_cnt++;
                stk_k = k;
            end
        end
        check_int("b_visible_cycles_frame", vis, 32);
        check_int("b_vsync_low_cycles", vsl, 12);
        check_int("b_hsync_low_cycles", hsl, 2);
        check_int("b_frame_start_count", fs_cnt, 62);
        check_int("b_frame_start_period", fs_gap, 84);
`ifdef VGA_FRAME_TICK_EN
        check_int("b_sec_tick_count", stk_cnt, 1);
        check_int("b_sec_tick_position", stk_k, 60 * 84);
`endif
        done_b = 1'b1;
    end

    // ---------------- final report ----------------
    initial begin : report
        for (int i = 0; i < 20000 && !(done_a && done_b); i++) @(negedge clk);
        if (!(done_a && done_b)) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: done_a=%0b done_b=%0b, required both 1", done_a, done_b);
        end
        repeat (2) @(negedge clk);
        check_int("a_queue_drained", exp_a_q.size(), 0);
        check_int("b_queue_drained", exp_b_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
